// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer for SimpleCPU: walks each instruction through
// FETCH, WAIT, DECODE, EXEC and WB, driving the PC, IR, ALU and register-file strobes.
module seq_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [15:0]       mem_data,
  input  logic              zero,
  output logic              mem_rd,
  output logic              ir_load,
  output logic [15:0]       ir,
  output logic [3:0]        alu_op,
  output logic              reg_we,
  output logic              ipc,
  output logic              epc,
  output logic [ADDR_W-1:0] jaddr,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_RSV = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_e           state_q, state_d;
  logic [15:0]      ir_q, ir_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  logic [3:0] opcode;
  logic       isAlu;

  assign opcode = ir_q[15:12];
  assign isAlu  = (opcode != OP_NOP) && (opcode < OP_JMP);

  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE:   if (start) state_d = FETCH;
      FETCH:  state_d = WAIT;
      WAIT: begin
        if (mem_ready) begin
          ir_d    = mem_data;
          state_d = DECODE;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        if (opcode == OP_RSV) begin
          state_d   = HALT;
          illegal_d = 1'b1;
        end else if (opcode == OP_HLT) begin
          state_d = HALT;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        retired_d = retired_q + CNT_W'(1);
        state_d   = FETCH;
      end
      HALT:   state_d = HALT;
      // The unused code 7 recovers to IDLE rather than locking up.
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ir_q      <= 16'h0000;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes follow the registered state; only ir_load and the JZ epc see live inputs.
  always_comb begin
    mem_rd  = 1'b0;
    ir_load = 1'b0;
    alu_op  = 4'h0;
    reg_we  = 1'b0;
    ipc     = 1'b0;
    epc     = 1'b0;
    case (state_q)
      FETCH: mem_rd = 1'b1;
      WAIT: begin
        mem_rd  = 1'b1;
        ir_load = mem_ready;
      end
      EXEC: begin
        if (isAlu) alu_op = opcode;
        if (opcode == OP_JMP) epc = 1'b1;
        if (opcode == OP_JZ)  epc = zero;
      end
      WB: begin
        ipc = 1'b1;
        if (isAlu) begin
          alu_op = opcode;
          reg_we = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign ir      = ir_q;
  assign jaddr   = ADDR_W'(ir_q[11:0]);
  assign halted  = (state_q == HALT);
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: doc/seq_ctrl.md
# seq_ctrl

Multi-cycle instruction sequencer for the SimpleCPU core. It drives the program counter's increment and load strobes, the instruction-memory read handshake, the instruction-register load and the ALU/register-file control lines. It sits between instruction memory, the PC block and the datapath. Each instruction passes through FETCH, WAIT, DECODE, EXEC and WB.

## Interface
Parameters:
- `ADDR_W`, 16: PC/jump address width.
- `CNT_W`, 16: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: leaves IDLE; sampled only in IDLE.
- `mem_ready` input 1: instruction memory has valid data on `mem_data`.
- `mem_data` input 16: instruction word.
- `zero` input 1: ALU zero flag, used by JZ.
- `mem_rd` output 1: instruction read request.
- `ir_load` output 1: IR capture strobe (mirror for datapath).
- `ir` output 16: current instruction register.
- `alu_op` output 4: ALU operation code.
- `reg_we` output 1: register-file write enable.
- `ipc` output 1: PC increment strobe.
- `epc` output 1: PC load strobe.
- `jaddr` output ADDR_W: PC load value, `{4'b0, ir[11:0]}`.
- `halted` output 1: in HALT.
- `illegal` output 1: HALT entered via reserved opcode (sticky).
- `retired` output CNT_W: instructions completed.

## Operation
- State register is 3 bits. Encoding: IDLE=0, FETCH=1, WAIT=2, DECODE=3, EXEC=4, WB=5, HALT=6. Code 7 goes to IDLE.
- IDLE: all strobes are 0. Goes to FETCH when `start`=1, otherwise stays in IDLE.
- FETCH: `mem_rd`=1. Always goes to WAIT.
- WAIT: `mem_rd`=1.
  - If `mem_ready`=1: `ir_load`=1, IR captures `mem_data` on this edge, next state is DECODE.
  - Otherwise stays in WAIT with no timeout.
- DECODE: opcode is `ir[15:12]`. Always goes to EXEC.
- EXEC by opcode:
  - 0x0 NOP: no strobes.
  - 0x1–0xB: `alu_op`=opcode.
  - 0xC JMP: `epc`=1.
  - 0xD JZ: `epc`=`zero`.
  - 0xE reserved: goes to HALT and sets `illegal`.
  - 0xF HLT: goes to HALT.
  - All other opcodes go to WB.
- WB:
  - `ipc`=1 for every instruction that reaches WB.
  - `reg_we`=1 and `alu_op` held for opcodes 0x1–0xB.
  - `retired` increments by 1 and wraps from all-ones to 0.
  - Next state is FETCH.
- Jump rule: the PC block loads `jaddr`−1 on `epc`. The WB `ipc` then brings the PC to exactly `jaddr`. `ipc` and `epc` are never asserted in the same cycle.
- HALT: `halted`=1, all strobes 0. Exit only by `reset`. `start` is ignored. HLT and illegal opcodes do not increment `retired` and do not pulse `ipc`.
- `alu_op` is 0 in every state other than EXEC and WB.

## Timing
- Reset (asynchronous, active-low) forces immediately:
  - state=IDLE; `ir`=0; `retired`=0; `illegal`=0.
  - All strobes 0 and `halted`=0.
  - This applies mid-instruction too: an in-flight fetch is abandoned and `mem_rd` drops at once.
- Strobes are decoded combinationally from the registered state and `ir` only. They never depend on `start`, `mem_ready` or `zero` combinationally, except:
  - `ir_load`, which equals WAIT & `mem_ready`;
  - `epc` for JZ, which equals EXEC & `zero`.
- Latency: with `mem_ready` high on the first WAIT cycle, one instruction takes 5 cycles (FETCH, WAIT, DECODE, EXEC, WB). Each extra WAIT cycle adds 1.
- `start` held high continuously has no effect outside IDLE.
- Increment of `retired` is visible the cycle after WB.

## Test plan
- Reset, then `start` pulse, memory returns 0x0000 (NOP) with `mem_ready` always high → `mem_rd` in cycles 1–2, `ipc` single pulse in cycle 5, `retired`=1 after 5 cycles, state back in FETCH.
- Fetch 0x3abc with `mem_ready` delayed 3 cycles → WAIT held 4 cycles with `mem_rd`=1; then `alu_op`=3 in EXEC and WB, `reg_we`=1 only in WB; total 8 cycles.
- Fetch 0xC123 → `epc`=1 in EXEC with `jaddr`=0x0123; `ipc` in the following WB; `epc` and `ipc` never both high.
- Fetch 0xD050, once with `zero`=0 and once with `zero`=1 → no `epc` / `epc` in EXEC with `jaddr`=0x0050; `ipc` in WB in both cases.
- Fetch 0xF000, then 0xE000 after a reset → `halted`=1 and `retired` unchanged in both cases; `illegal`=0 for 0xF000 and `illegal`=1 for 0xE000; `start` pulses have no effect until reset.
- Assert `reset` low during WAIT of a pending fetch, and separately preload `retired` to 0xFFFF before one NOP → all outputs 0 and state IDLE asynchronously; `retired` wraps to 0x0000 after the NOP.
